// File: rtl/player_state_tx.sv
// player_state_tx: snapshots the local player state and streams it as a 7-byte frame
// (header, 5 payload bytes, XOR checksum) of LSB-first dibits, on request or periodically.
module player_state_tx #(
    parameter int unsigned PERIOD = 833334,
    parameter int unsigned IFG    = 12,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_in,
    input  logic [10:0] player_x_in,
    input  logic [10:0] player_y_in,
    input  logic [8:0]  player_dir_in,
    input  logic [2:0]  game_status_in,
    output logic        axiov,
    output logic [1:0]  axiod,
    output logic        busy_out,
    output logic        frame_done_out
);

    localparam int unsigned      CNT_W      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned      GAP_W      = (IFG > 1) ? $clog2(IFG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = (PERIOD > 0) ? CNT_W'(PERIOD - 1) : '0;
    localparam logic [GAP_W-1:0] GAP_LAST   = (IFG > 0) ? GAP_W'(IFG - 1) : '0;
    localparam logic [4:0]       LAST_DIBIT = 5'd27;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [4:0]       idx_q, idx_d;
    logic             pending_q, pending_d;
    logic             frame_done_q, frame_done_d;
    logic [39:0]      payload_q, payload_d;

    logic       tick;
    logic       trigger;
    logic       start_frame;
    logic [7:0] checksum;
    logic [7:0] cur_byte;
    logic [1:0] dibit;

    // Free-running period counter; it keeps counting while a frame is in flight.
    always_comb begin
        tick  = (PERIOD != 0) && (cnt_q == CNT_LAST);
        cnt_d = '0;
        if ((PERIOD != 0) && !tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign trigger = send_in | tick;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d      = state_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        pending_d    = pending_q;
        payload_d    = payload_q;
        frame_done_d = 1'b0;
        start_frame  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger || pending_q) start_frame = 1'b1;
            end
            ST_SEND: begin
                if (idx_q == LAST_DIBIT) begin
                    frame_done_d = 1'b1;
                    if (IFG == 0) begin
                        if (pending_q || trigger) start_frame = 1'b1;
                        else                      state_d     = ST_IDLE;
                    end else begin
                        state_d   = ST_GAP;
                        gap_d     = '0;
                        pending_d = pending_q | trigger;
                    end
                end else begin
                    idx_d     = idx_q + 5'd1;
                    pending_d = pending_q | trigger;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (pending_q || trigger) start_frame = 1'b1;
                    else                      state_d     = ST_IDLE;
                end else begin
                    gap_d     = gap_q + GAP_W'(1);
                    pending_d = pending_q | trigger;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The snapshot is taken on the same edge that enters SEND, so a deferred
        // frame carries the inputs present when it actually starts.
        if (start_frame) begin
            state_d   = ST_SEND;
            idx_d     = '0;
            pending_d = 1'b0;
            payload_d = {player_x_in, player_y_in, player_dir_in, game_status_in, 6'b0};
        end
    end

    always_comb begin
        checksum = payload_q[39:32] ^ payload_q[31:24] ^ payload_q[23:16]
                 ^ payload_q[15:8]  ^ payload_q[7:0];
        cur_byte = 8'h00;
        unique case (idx_q[4:2])
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = payload_q[39:32];
            3'd2:    cur_byte = payload_q[31:24];
            3'd3:    cur_byte = payload_q[23:16];
            3'd4:    cur_byte = payload_q[15:8];
            3'd5:    cur_byte = payload_q[7:0];
            3'd6:    cur_byte = checksum;
            default: cur_byte = 8'h00;
        endcase
        dibit = cur_byte[1:0];
        unique case (idx_q[1:0])
            2'd0:    dibit = cur_byte[1:0];
            2'd1:    dibit = cur_byte[3:2];
            2'd2:    dibit = cur_byte[5:4];
            default: dibit = cur_byte[7:6];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            gap_q        <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            payload_q    <= '0;
        end else begin
            // NOTE: non-blocking so every flop updates from values sampled before the edge.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            payload_q    <= payload_d;
        end
    end

    assign axiov          = (state_q == ST_SEND);
    assign axiod          = axiov ? dibit : 2'b00;
    assign busy_out       = (state_q != ST_IDLE);
    assign frame_done_out = frame_done_q;

endmodule

// File: tb/tb_player_state_tx.sv
// Bench for player_state_tx: two instances (periodic IFG=4, on-demand IFG=0) checked every
// cycle against a time-based frame model, plus directed frame, pending, tick and reset steps.
module tb_player_state_tx;

    localparam int unsigned PER_A = 100;
    localparam int unsigned IFG_A = 4;
    localparam int unsigned PER_B = 0;
    localparam int unsigned IFG_B = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        send_in;
    logic [10:0] x_in, y_in;
    logic [8:0]  dir_in;
    logic [2:0]  st_in;

    logic       axiov_a, busy_a, done_a;
    logic [1:0] axiod_a;
    logic       axiov_b, busy_b, done_b;
    logic [1:0] axiod_b;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #10 clk = ~clk;

    player_state_tx #(.PERIOD(PER_A), .IFG(IFG_A), .HEADER(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .send_in(send_in),
        .player_x_in(x_in), .player_y_in(y_in), .player_dir_in(dir_in), .game_status_in(st_in),
        .axiov(axiov_a), .axiod(axiod_a), .busy_out(busy_a), .frame_done_out(done_a)
    );

    player_state_tx #(.PERIOD(PER_B), .IFG(IFG_B), .HEADER(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .send_in(send_in),
        .player_x_in(x_in), .player_y_in(y_in), .player_dir_in(dir_in), .game_status_in(st_in),
        .axiov(axiov_b), .axiod(axiod_b), .busy_out(busy_b), .frame_done_out(done_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [39:0] pack(input logic [10:0] x, input logic [10:0] y,
                                         input logic [8:0] dir, input logic [2:0] st);
        return {x, y, dir, st, 6'b0};
    endfunction

    function automatic logic [7:0] frame_byte(input logic [39:0] p, input int i);
        logic [7:0] b [5];
        for (int j = 0; j < 5; j++) b[j] = p[39-8*j -: 8];
        if (i == 0) return 8'hA5;
        if (i == 6) return b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
        return b[i-1];
    endfunction

    function automatic int per_of(input int d);
        return (d == 0) ? int'(PER_A) : int'(PER_B);
    endfunction

    function automatic int ifg_of(input int d);
        return (d == 0) ? int'(IFG_A) : int'(IFG_B);
    endfunction

    function automatic bit trig_of(input int d, input longint e);
        return send_in || (per_of(d) != 0 && (e % per_of(d)) == 0);
    endfunction

    // k counts clock edges since reset release; a frame started at edge s owns
    // dibit cycles s..s+27 and the channel is free again from edge s+28+IFG.
    longint      k = 0;
    longint      m_start [2] = '{-1000, -1000};
    longint      m_prev  [2] = '{-1000, -1000};
    bit          m_pend  [2] = '{0, 0};
    logic [39:0] m_pay   [2] = '{40'd0, 40'd0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= 0;
            for (int d = 0; d < 2; d++) begin
                m_start[d] <= -1000;
                m_prev[d]  <= -1000;
                m_pend[d]  <= 1'b0;
                m_pay[d]   <= '0;
            end
        end else begin
            k <= k + 1;
            for (int d = 0; d < 2; d++) begin
                if (k + 1 >= m_start[d] + 28 + ifg_of(d)) begin
                    if (m_pend[d] || trig_of(d, k + 1)) begin
                        m_prev[d]  <= m_start[d];
                        m_start[d] <= k + 1;
                        m_pay[d]   <= pack(x_in, y_in, dir_in, st_in);
                        m_pend[d]  <= 1'b0;
                    end
                end else if (trig_of(d, k + 1)) begin
                    m_pend[d] <= 1'b1;
                end
            end
        end
    end

    task automatic check_outputs(input int d, input string pfx, input logic v,
                                 input logic [1:0] dd, input logic b, input logic fd);
        longint     off;
        logic       ev, eb, efd;
        logic [1:0] ed;
        logic [7:0] byt;
        off = k - m_start[d];
        ev  = (off >= 0) && (off < 28);
        eb  = (off >= 0) && (off <= 27 + ifg_of(d));
        efd = (off == 28) || (k - m_prev[d] == 28);
        ed  = 2'b00;
        if (ev) begin
            byt = frame_byte(m_pay[d], int'(off / 4));
            byt = byt >> (2 * int'(off % 4));
            ed  = byt[1:0];
        end
        check({pfx, "_axiov"}, v, ev);
        check({pfx, "_axiod"}, dd, ed);
        check({pfx, "_busy"}, b, eb);
        check({pfx, "_frame_done"}, fd, efd);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_outputs(0, "a", axiov_a, axiod_a, busy_a, done_a);
            check_outputs(1, "b", axiov_b, axiod_b, busy_b, done_b);
        end
    end

    // ---------------- directed helpers ----------------
    logic [1:0] cap_dib   [28];
    logic [7:0] cap_bytes [7];
    int         cap_valid, cap_done, cap_last;

    task automatic pulse_send();
        send_in = 1'b1;
        @(negedge clk);
        #1;
        send_in = 1'b0;
    endtask

    task automatic randomize_inputs();
        x_in   = 11'($urandom);
        y_in   = 11'($urandom);
        dir_in = 9'($urandom);
        st_in  = 3'($urandom);
    endtask

    // Starts in the first dibit cycle of a frame on instance a; inputs are scrambled throughout.
    task automatic capture_frame();
        cap_valid = 0;
        cap_done  = -1;
        cap_last  = -1;
        for (int c = 0; c < 40; c++) begin
            if (axiov_a) begin
                if (cap_valid < 28) cap_dib[cap_valid] = axiod_a;
                cap_valid++;
                cap_last = c;
            end
            if (done_a && cap_done < 0) cap_done = c;
            randomize_inputs();
            @(negedge clk);
            #1;
        end
        for (int i = 0; i < 7; i++)
            cap_bytes[i] = {cap_dib[4*i+3], cap_dib[4*i+2], cap_dib[4*i+1], cap_dib[4*i]};
    endtask

    task automatic sync_phase(input int ph);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((k % 100) != ph && n < 300);
        check("sync_timeout", (n < 300), 1'b1);
        #1;
    endtask

    logic [7:0] t1_bytes [7]  = '{8'hA5, 8'hFF, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h1F};
    logic [1:0] t1_dibs  [12] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3,
                                  2'd0, 2'd0, 2'd2, 2'd3};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [39:0] snap;
        logic [7:0]  xsum;
        int a_starts, a_done, a_second, b_starts, b_run, b_max, b_done;
        logic prev_a, prev_b, b_done_v;
        longint rise_k [4];
        int nr;

        rst = 1'b1;
        send_in = 1'b0;
        x_in = '0; y_in = '0; dir_in = '0; st_in = '0;
        @(negedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_axiov", axiov_a, 1'b0);
        check("rst_axiod", axiod_a, 2'b00);
        check("rst_busy", busy_a, 1'b0);
        check("rst_frame_done", done_a, 1'b0);
        rst = 1'b0;

        // Known frame right after reset.
        x_in = 11'h7FF; y_in = 11'h000; dir_in = 9'h000; st_in = 3'b000;
        pulse_send();
        capture_frame();
        for (int i = 0; i < 7; i++) check("t1_byte", cap_bytes[i], t1_bytes[i]);
        for (int i = 0; i < 12; i++) check("t1_dibit", cap_dib[i], t1_dibs[i]);
        check("t1_valid_count", cap_valid, 28);
        check("t1_last_valid", cap_last, 27);
        check("t1_done_pos", cap_done, 28);

        // Snapshot isolation and checksum.
        sync_phase(32);
        x_in = 11'h123; y_in = 11'h456; dir_in = 9'h1AB; st_in = 3'b101;
        snap = pack(11'h123, 11'h456, 9'h1AB, 3'b101);
        pulse_send();
        capture_frame();
        for (int i = 0; i < 7; i++) check("t2_byte", cap_bytes[i], frame_byte(snap, i));
        xsum = cap_bytes[1] ^ cap_bytes[2] ^ cap_bytes[3] ^ cap_bytes[4] ^ cap_bytes[5];
        check("t2_checksum", cap_bytes[6], xsum);
        check("t2_valid_count", cap_valid, 28);

        // Three requests during SEND: one deferred frame; IFG=0 instance runs back-to-back.
        sync_phase(32);
        randomize_inputs();
        pulse_send();
        a_starts = 0; a_done = -1; a_second = -1; prev_a = 1'b0;
        b_starts = 0; b_run = 0; b_max = 0; b_done = -1; b_done_v = 1'b0; prev_b = 1'b0;
        for (int c = 0; c < 66; c++) begin
            if (axiov_a && !prev_a) begin
                a_starts++;
                if (a_starts == 2) a_second = c;
            end
            prev_a = axiov_a;
            if (done_a && a_done < 0) a_done = c;
            if (axiov_b && !prev_b) b_starts++;
            prev_b = axiov_b;
            b_run = axiov_b ? b_run + 1 : 0;
            if (b_run > b_max) b_max = b_run;
            if (done_b && b_done < 0) begin
                b_done   = c;
                b_done_v = axiov_b;
            end
            send_in = (c == 3 || c == 6 || c == 9);
            randomize_inputs();
            @(negedge clk);
            #1;
        end
        send_in = 1'b0;
        check("t3_frame_count", a_starts, 2);
        check("t3_done_pos", a_done, 28);
        check("t3_gap_to_next", a_second - a_done, IFG_A);
        check("t6_run_length", b_max, 56);
        check("t6_start_count", b_starts, 1);
        check("t6_done_pos", b_done, 28);
        check("t6_done_during_valid", b_done_v, 1'b1);

        // Asynchronous reset at dibit 10.
        sync_phase(32);
        pulse_send();
        repeat (10) @(negedge clk);
        #2;
        check("t5_mid_frame", axiov_a, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_axiov_a", axiov_a, 1'b0);
        check("t5_axiod_a", axiod_a, 2'b00);
        check("t5_busy_a", busy_a, 1'b0);
        check("t5_done_a", done_a, 1'b0);
        check("t5_axiov_b", axiov_b, 1'b0);
        check("t5_axiod_b", axiod_b, 2'b00);
        check("t5_busy_b", busy_b, 1'b0);
        check("t5_done_b", done_b, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;

        // Auto ticks after release, plus a send coincident with the tick at edge 200.
        nr = 0;
        prev_a = 1'b0;
        for (int c = 0; c < 320; c++) begin
            @(negedge clk);
            if (axiov_a && !prev_a) begin
                if (nr < 4) rise_k[nr] = k;
                nr++;
            end
            prev_a = axiov_a;
            #1;
            send_in = (k == 199);
        end
        send_in = 1'b0;
        check("t4_start_count", nr, 3);
        check("t4_start_1", rise_k[0], 100);
        check("t4_start_2", rise_k[1], 200);
        check("t4_start_3", rise_k[2], 300);

        // Random traffic against the model.
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            #1;
            send_in = ($urandom_range(0, 11) == 0);
            randomize_inputs();
        end
        send_in = 1'b0;
        repeat (60) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
